// File: rtl/jt5205_pkg.sv
// Shared constants for the MSM5205-compatible ADPCM decoder: step table,
// rate-select encoding and the index/difference helpers.
package jt5205_pkg;

  typedef enum logic [1:0] {
    SEL_96   = 2'b00,
    SEL_48   = 2'b01,
    SEL_64   = 2'b10,
    SEL_STOP = 2'b11
  } sel_e;

  localparam logic [5:0]         IDX_MAX    = 6'd48;
  localparam logic signed [13:0] SAMPLE_MAX = 14'sd2047;
  localparam logic signed [13:0] SAMPLE_MIN = -14'sd2048;

  localparam logic [10:0] STEP_TABLE [49] = '{
    11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
    11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
    11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
    11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
    11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
    11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
    11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
  };

  // Divider length in cen pulses; 0 for the stopped setting.
  function automatic logic [6:0] div_len(input sel_e s);
    case (s)
      SEL_96:  return 7'd96;
      SEL_48:  return 7'd48;
      SEL_64:  return 7'd64;
      default: return 7'd0;
    endcase
  endfunction

  function automatic logic signed [6:0] idx_delta(input logic [2:0] mag);
    case (mag)
      3'd4:    return 7'sd2;
      3'd5:    return 7'sd4;
      3'd6:    return 7'sd6;
      3'd7:    return 7'sd8;
      default: return -7'sd1;
    endcase
  endfunction

  function automatic logic [5:0] next_idx(input logic [5:0] idx, input logic [2:0] mag);
    logic signed [6:0] t;
    t = $signed({1'b0, idx}) + idx_delta(mag);
    if (t < 7'sd0)                        return 6'd0;
    else if (t > $signed({1'b0, IDX_MAX})) return IDX_MAX;
    else                                  return t[5:0];
  endfunction

  // Largest result is 194+1552+776+388 = 2910, so 12 bits never overflow.
  function automatic logic [11:0] adpcm_diff(input logic [10:0] step, input logic [2:0] mag);
    logic [11:0] s;
    s = {1'b0, step};
    return (s >> 3) + (mag[2] ? s : 12'd0) + (mag[1] ? (s >> 1) : 12'd0)
         + (mag[0] ? (s >> 2) : 12'd0);
  endfunction

endpackage

// File: rtl/jt5205_timing.sv
// Sample-rate divider: produces the VCK square wave and a one-clk strobe on
// the cen cycle where a new sample period begins.
module jt5205_timing
  import jt5205_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic [1:0] sel,
  output logic       irq,
  output logic       sample
);

  logic [6:0] count;
  logic [6:0] count_next;
  logic [6:0] len;
  logic       stop;
  logic       wrap;

  // NOTE: every signal driven here gets its default first so no latch can form.
  always_comb begin
    len  = div_len(sel_e'(sel));
    stop = (sel_e'(sel) == SEL_STOP);
    // Leaving reset/stop (count 0 with irq low) starts a period immediately;
    // a count at or past the end, e.g. after a rate change, wraps at once.
    wrap       = (!irq && count == 7'd0) || (count >= len - 7'd1);
    count_next = wrap ? 7'd0 : count + 7'd1;
    sample     = cen && !stop && wrap;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 7'd0;
      irq   <= 1'b0;
    end else if (cen) begin
      if (stop) begin
        count <= 7'd0;
        irq   <= 1'b0;
      end else begin
        count <= count_next;
        irq   <= (count_next < (len >> 1));
      end
    end
  end

endmodule

// File: rtl/jt5205_adpcm.sv
// MSM5205-compatible 4-bit ADPCM decoder: latch nibble at each period start,
// then a two-cen pipeline (difference, then saturated accumulate + index).
module jt5205_adpcm
  import jt5205_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic [1:0]  sel,
  input  logic [3:0]  din,
  output logic [11:0] sound,
  output logic        irq
);

  logic        sample;
  logic [3:0]  nibble;
  logic [5:0]  idx;
  logic [11:0] diff;
  logic        stage_diff;
  logic        stage_acc;
  logic [13:0] acc;
  logic [11:0] sound_next;

  jt5205_timing u_timing (
    .clk    (clk),
    .rst    (rst),
    .cen    (cen),
    .sel    (sel),
    .irq    (irq),
    .sample (sample)
  );

  always_comb begin
    acc = nibble[3] ? {{2{sound[11]}}, sound} - {2'b00, diff}
                    : {{2{sound[11]}}, sound} + {2'b00, diff};
    if ($signed(acc) > SAMPLE_MAX)      sound_next = SAMPLE_MAX[11:0];
    else if ($signed(acc) < SAMPLE_MIN) sound_next = SAMPLE_MIN[11:0];
    else                                sound_next = acc[11:0];
  end

  // The index written by the accumulate stage is only read by the next
  // nibble's difference stage, a full period later.
  always_ff @(posedge clk) begin
    if (rst) begin
      nibble     <= 4'd0;
      idx        <= 6'd0;
      diff       <= 12'd0;
      stage_diff <= 1'b0;
      stage_acc  <= 1'b0;
      sound      <= 12'd0;
    end else if (cen) begin
      stage_diff <= sample;
      stage_acc  <= stage_diff;
      if (sample)
        nibble <= din;
      if (stage_diff)
        diff <= adpcm_diff(STEP_TABLE[idx], nibble[2:0]);
      if (stage_acc) begin
        sound <= sound_next;
        idx   <= next_idx(idx, nibble[2:0]);
      end
    end
  end

endmodule

// File: tb/tb_jt5205_adpcm.sv
// Scoreboard bench for jt5205_adpcm: a reference decoder pushes expected
// samples as nibbles are presented; they are popped when irq falls.
module tb_jt5205_adpcm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b0;
  logic [1:0]  sel = 2'b10;
  logic [3:0]  din = 4'd0;
  logic [11:0] sound;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  int ref_idx  = 0;
  int ref_sound = 0;
  int exp_q[$];

  localparam int STEPS [49] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
    253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963,
    1060, 1166, 1282, 1411, 1552};

  jt5205_adpcm dut (
    .clk   (clk),
    .rst   (rst),
    .cen   (cen),
    .sel   (sel),
    .din   (din),
    .sound (sound),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    cen = ~cen;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_nibble(input int nib);
    int step, d, mag;
    step = STEPS[ref_idx];
    mag  = nib % 8;
    d = step / 8;
    if (mag >= 4)      d += step;
    if ((mag / 2) % 2) d += step / 2;
    if (mag % 2)       d += step / 4;
    ref_sound = (nib >= 8) ? ref_sound - d : ref_sound + d;
    if (ref_sound > 2047)  ref_sound = 2047;
    if (ref_sound < -2048) ref_sound = -2048;
    ref_idx += (mag < 4) ? -1 : (mag - 3) * 2;
    if (ref_idx < 0)  ref_idx = 0;
    if (ref_idx > 48) ref_idx = 48;
  endfunction

  task automatic wait_level(input logic lvl, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (irq !== lvl && n < 2000);
    if (irq !== lvl) check({tag, "_timeout"}, int'(irq), int'(lvl));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sound", int'($signed(sound)), 0);
    check("rst_irq", int'(irq), 0);
    rst = 1'b0;
    ref_idx = 0;
    ref_sound = 0;
    exp_q.delete();
  endtask

  // Present a nibble; it is latched at the next irq rise and its result is
  // settled by the following irq fall.
  task automatic feed(input int nib, input string tag);
    din = 4'(nib);
    model_nibble(nib);
    exp_q.push_back(ref_sound);
    wait_level(1'b1, tag);
    wait_level(1'b0, tag);
    check(tag, int'($signed(sound)), exp_q.pop_front());
  endtask

  task automatic measure(input int exp_per, input string tag);
    int n = 0;
    int hi = -1;
    bit done = 0;
    logic prev;
    wait_level(1'b0, tag);
    wait_level(1'b1, tag);
    prev = 1'b1;
    while (!done && n < 1000) begin
      @(posedge clk);
      if (cen) n++;
      @(negedge clk);
      if (prev && !irq) hi = n;
      if (!prev && irq) done = 1;
      prev = irq;
    end
    check({tag, "_period"}, n, exp_per);
    check({tag, "_high"}, hi, exp_per / 2);
  endtask

  initial begin
    bit saw_irq;

    // Reset state, then rate /64 period and idle output before first decode.
    sel = 2'b10;
    din = 4'd0;
    do_reset();
    wait_level(1'b1, "first_rise");
    check("pre_decode_sound", int'($signed(sound)), 0);
    measure(64, "sel64");

    // Basic decode from a fresh history.
    do_reset();
    feed(7, "n7_first");
    feed(0, "n0_after7");

    // Index floor clamp and negative samples.
    do_reset();
    feed(8, "n8_first");
    feed(15, "nF_after8");

    // Saturation at both rails.
    do_reset();
    for (int i = 0; i < 8; i++) feed(7, "ramp_up");
    check("sat_hi", int'($signed(sound)), 2047);
    for (int i = 0; i < 8; i++) feed(15, "ramp_down");
    check("sat_lo", int'($signed(sound)), -2048);

    // Stopped: irq stays low, sound holds.
    @(negedge clk);
    sel = 2'b11;
    saw_irq = 0;
    repeat (400) begin
      @(negedge clk);
      if (irq) saw_irq = 1;
    end
    check("stop_irq", int'(saw_irq), 0);
    check("stop_sound", int'($signed(sound)), ref_sound);

    // Other rates.
    sel = 2'b00;
    measure(96, "sel96");
    sel = 2'b01;
    measure(48, "sel48");

    // Mid-period reset discards history.
    sel = 2'b10;
    do_reset();
    feed(7, "pre_rst_a");
    feed(4, "pre_rst_b");
    feed(9, "pre_rst_c");
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_sound", int'($signed(sound)), 0);
    check("midrst_irq", int'(irq), 0);
    ref_idx = 0;
    ref_sound = 0;
    exp_q.delete();
    feed(7, "post_rst_n7");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
